// File: rtl/clock_pkg.sv
// Shared constants and FSM state type for the time-of-day keeper and display path.
package clock_pkg;

    localparam logic [4:0] HR_MAX  = 5'd23;
    localparam logic [5:0] MIN_MAX = 6'd59;
    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam logic [4:0] HR_NOON = 5'd12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        LOADED = 2'd2
    } state_e;

endpackage

// File: rtl/h24_to_h12.sv
// Purely combinational 24h hour to 12h hour + AM/PM flag conversion.
module h24_to_h12
    import clock_pkg::*;
(
    input  logic [4:0] hr24_i,
    output logic [3:0] h12_o,
    output logic       pm_o
);

    // Midnight and noon both display as 12; afternoon hours drop by 12.
    always_comb begin
        h12_o = hr24_i[3:0];
        pm_o  = 1'b0;
        if (hr24_i == 5'd0) begin
            h12_o = HR_NOON[3:0];
        end else if (hr24_i == HR_NOON) begin
            pm_o  = 1'b1;
        end else if (hr24_i > HR_NOON) begin
            h12_o = 4'(hr24_i - HR_NOON);
            pm_o  = 1'b1;
        end
    end

endmodule

// File: rtl/h24_h12_clock.sv
// Free-running 24h time-of-day keeper with loadable time and registered 12h display.
module h24_h12_clock
    import clock_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [4:0] load_h24,
    input  logic [5:0] load_min,
    input  logic [5:0] load_sec,
    output logic [3:0] h12,
    output logic       pm,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       upd,
    output logic       load_err
);

    localparam int unsigned     PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]   PMAX = PW'(CLK_DIV - 1);

    state_e        state_q, state_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [4:0]    hr_q, hr_d;
    logic [5:0]    mn_q, mn_d;
    logic [5:0]    sc_q, sc_d;
    logic          chg_q, err_q;
    logic [3:0]    h12_q;
    logic          pm_q, upd_q, load_err_q;
    logic [5:0]    min_q, sec_q;

    logic          load_legal, load_acc, load_bad, adv, tick;
    logic [3:0]    conv_h12;
    logic          conv_pm;

    assign load_ready = 1'b1;
    assign load_legal = (load_h24 <= HR_MAX) && (load_min <= MIN_MAX) && (load_sec <= SEC_MAX);
    assign load_acc   = load_valid && load_legal;
    assign load_bad   = load_valid && !load_legal;
    // Any load request freezes the prescaler for that cycle: a legal one
    // overwrites the time, an illegal one must leave time and pcnt untouched,
    // which also keeps upd and load_err mutually exclusive.
    assign adv        = run && (state_q != IDLE) && !load_valid;
    assign tick       = adv && (pcnt_q == PMAX);

    h24_to_h12 u_conv (
        .hr24_i (hr_q),
        .h12_o  (conv_h12),
        .pm_o   (conv_pm)
    );

    // Next-state logic: FSM, prescaler and time counters with carry chain.
    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        hr_d    = hr_q;
        mn_d    = mn_q;
        sc_d    = sc_q;

        case (state_q)
            IDLE:    if (run)  state_d = COUNT;
            COUNT:   if (!run) state_d = IDLE;
            LOADED:  state_d = run ? COUNT : IDLE;
            default: state_d = IDLE;
        endcase
        if (load_acc) state_d = LOADED;

        if (load_acc) begin
            pcnt_d = '0;
            hr_d   = load_h24;
            mn_d   = load_min;
            sc_d   = load_sec;
        end else if (adv) begin
            pcnt_d = tick ? '0 : pcnt_q + 1'b1;
            if (tick) begin
                if (sc_q == SEC_MAX) begin
                    sc_d = '0;
                    if (mn_q == MIN_MAX) begin
                        mn_d = '0;
                        hr_d = (hr_q == HR_MAX) ? '0 : hr_q + 5'd1;
                    end else begin
                        mn_d = mn_q + 6'd1;
                    end
                end else begin
                    sc_d = sc_q + 6'd1;
                end
            end
        end
    end

    // Core state: FSM, prescaler, 24h time and one-cycle event flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pcnt_q  <= '0;
            hr_q    <= '0;
            mn_q    <= '0;
            sc_q    <= '0;
            chg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            hr_q    <= hr_d;
            mn_q    <= mn_d;
            sc_q    <= sc_d;
            chg_q   <= load_acc || tick;
            err_q   <= load_bad;
        end
    end

    // Registered display outputs, one cycle behind the internal time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h12_q      <= 4'd12;
            pm_q       <= 1'b0;
            min_q      <= '0;
            sec_q      <= '0;
            upd_q      <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            h12_q      <= conv_h12;
            pm_q       <= conv_pm;
            min_q      <= mn_q;
            sec_q      <= sc_q;
            upd_q      <= chg_q;
            load_err_q <= err_q;
        end
    end

    assign h12      = h12_q;
    assign pm       = pm_q;
    assign min      = min_q;
    assign sec      = sec_q;
    assign upd      = upd_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_h24_h12_clock.sv
// Scoreboard bench for h24_h12_clock with CLK_DIV = 4.
module tb_h24_h12_clock;

    localparam int unsigned DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n, run, load_valid;
    logic [4:0] load_h24;
    logic [5:0] load_min, load_sec;
    logic       load_ready;
    logic [3:0] h12;
    logic       pm;
    logic [5:0] min, sec;
    logic       upd, load_err;

    typedef struct packed {
        logic [3:0] h;
        logic       p;
        logic [5:0] m;
        logic [5:0] s;
    } disp_t;

    disp_t exp_q[$];
    disp_t got, want;
    int    tests = 0, fails = 0;
    int    upd_cnt = 0, err_cnt = 0, both_cnt = 0;
    int    base_u, base_e, base_t;

    h24_h12_clock #(.CLK_DIV(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_h24   (load_h24),
        .load_min   (load_min),
        .load_sec   (load_sec),
        .h12        (h12),
        .pm         (pm),
        .min        (min),
        .sec        (sec),
        .upd        (upd),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (upd === 1'b1) upd_cnt++;
        if (load_err === 1'b1) err_cnt++;
        if (upd === 1'b1 && load_err === 1'b1) both_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic disp_t ref_disp(input int hr, input int mn, input int sc);
        disp_t r;
        int    h;
        if (hr == 0)      h = 12;
        else if (hr > 12) h = hr - 12;
        else              h = hr;
        r.h = 4'(h);
        r.p = (hr >= 12);
        r.m = 6'(mn);
        r.s = 6'(sc);
        return r;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_load(input int hr, input int mn, input int sc);
        load_valid = 1'b1;
        load_h24   = 5'(hr);
        load_min   = 6'(mn);
        load_sec   = 6'(sc);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; load_valid = 1'b0;
        load_h24 = '0; load_min = '0; load_sec = '0;
        step(); step();
        rst_n = 1'b1;
        exp_q.push_back(ref_disp(0, 0, 0));
        step();
        got = {h12, pm, min, sec}; want = exp_q.pop_front(); tests++;
        if (got !== want) begin fails++; $display("FAIL reset_disp got=%h want=%h", got, want); end
        tests++;
        if ({load_ready, upd, load_err} !== 3'b100) begin
            fails++; $display("FAIL reset_flags got=%b want=100", {load_ready, upd, load_err});
        end
        base_u = upd_cnt;
        exp_q.push_back(ref_disp(0, 0, 0));
        repeat (20) step();
        got = {h12, pm, min, sec}; want = exp_q.pop_front(); tests++;
        if (got !== want) begin fails++; $display("FAIL idle_hold got=%h want=%h", got, want); end
        tests++;
        if (upd_cnt - base_u !== 0) begin fails++; $display("FAIL idle_upd got=%0d want=0", upd_cnt - base_u); end
    endtask

    task automatic test_noon_rollover();
        base_u = upd_cnt;
        set_load(11, 59, 58); run = 1'b1;
        exp_q.push_back(ref_disp(11, 59, 58));
        step(); load_valid = 1'b0;
        step();
        got = {h12, pm, min, sec}; want = exp_q.pop_front(); tests++;
        if (got !== want) begin fails++; $display("FAIL noon_load got=%h want=%h", got, want); end
        base_t = upd_cnt;
        exp_q.push_back(ref_disp(11, 59, 59));
        repeat (4) step();
        got = {h12, pm, min, sec}; want = exp_q.pop_front(); tests++;
        if (got !== want) begin fails++; $display("FAIL noon_tick1 got=%h want=%h", got, want); end
        exp_q.push_back(ref_disp(11, 59, 59));
        repeat (3) step();
        got = {h12, pm, min, sec}; want = exp_q.pop_front(); tests++;
        if (got !== want) begin fails++; $display("FAIL noon_hold got=%h want=%h", got, want); end
        exp_q.push_back(ref_disp(12, 0, 0));
        step();
        got = {h12, pm, min, sec}; want = exp_q.pop_front(); tests++;
        if (got !== want) begin fails++; $display("FAIL noon_tick2 got=%h want=%h", got, want); end
        tests++;
        if (upd_cnt - base_t !== 2) begin fails++; $display("FAIL noon_tick_upd got=%0d want=2", upd_cnt - base_t); end
        tests++;
        if (upd_cnt - base_u !== 3) begin fails++; $display("FAIL noon_all_upd got=%0d want=3", upd_cnt - base_u); end
        run = 1'b0;
        step();
    endtask

    task automatic test_midnight_wrap();
        set_load(23, 59, 59); run = 1'b1;
        exp_q.push_back(ref_disp(23, 59, 59));
        step(); load_valid = 1'b0;
        step();
        got = {h12, pm, min, sec}; want = exp_q.pop_front(); tests++;
        if (got !== want) begin fails++; $display("FAIL wrap_load got=%h want=%h", got, want); end
        exp_q.push_back(ref_disp(23, 59, 59));
        repeat (3) step();
        got = {h12, pm, min, sec}; want = exp_q.pop_front(); tests++;
        if (got !== want) begin fails++; $display("FAIL wrap_hold got=%h want=%h", got, want); end
        exp_q.push_back(ref_disp(0, 0, 0));
        step();
        got = {h12, pm, min, sec}; want = exp_q.pop_front(); tests++;
        if (got !== want) begin fails++; $display("FAIL wrap_tick got=%h want=%h", got, want); end
        run = 1'b0;
        step();
    endtask

    task automatic test_illegal_load();
        base_u = upd_cnt; base_e = err_cnt;
        set_load(24, 0, 0);
        step(); load_valid = 1'b0;
        tests++;
        if (load_err !== 1'b0) begin fails++; $display("FAIL err_early got=%b want=0", load_err); end
        step();
        tests++;
        if (load_err !== 1'b1) begin fails++; $display("FAIL err_hour got=%b want=1", load_err); end
        set_load(13, 60, 0);
        step(); load_valid = 1'b0;
        step();
        tests++;
        if (load_err !== 1'b1) begin fails++; $display("FAIL err_min got=%b want=1", load_err); end
        exp_q.push_back(ref_disp(0, 0, 0));
        step();
        got = {h12, pm, min, sec}; want = exp_q.pop_front(); tests++;
        if (got !== want) begin fails++; $display("FAIL err_unchanged got=%h want=%h", got, want); end
        tests++;
        if (err_cnt - base_e !== 2) begin fails++; $display("FAIL err_count got=%0d want=2", err_cnt - base_e); end
        tests++;
        if (upd_cnt - base_u !== 0) begin fails++; $display("FAIL err_upd got=%0d want=0", upd_cnt - base_u); end
    endtask

    task automatic test_load_on_tick();
        base_u = upd_cnt;
        set_load(8, 0, 0); run = 1'b1;
        exp_q.push_back(ref_disp(8, 0, 0));
        step(); load_valid = 1'b0;
        step();
        got = {h12, pm, min, sec}; want = exp_q.pop_front(); tests++;
        if (got !== want) begin fails++; $display("FAIL tick_pre_load got=%h want=%h", got, want); end
        exp_q.push_back(ref_disp(8, 0, 1));
        repeat (4) step();
        got = {h12, pm, min, sec}; want = exp_q.pop_front(); tests++;
        if (got !== want) begin fails++; $display("FAIL tick_pre_tick got=%h want=%h", got, want); end
        repeat (2) step();
        set_load(13, 5, 0);
        exp_q.push_back(ref_disp(13, 5, 0));
        step(); load_valid = 1'b0;
        step();
        got = {h12, pm, min, sec}; want = exp_q.pop_front(); tests++;
        if (got !== want) begin fails++; $display("FAIL tick_load_wins got=%h want=%h", got, want); end
        exp_q.push_back(ref_disp(13, 5, 0));
        repeat (3) step();
        got = {h12, pm, min, sec}; want = exp_q.pop_front(); tests++;
        if (got !== want) begin fails++; $display("FAIL tick_after_hold got=%h want=%h", got, want); end
        exp_q.push_back(ref_disp(13, 5, 1));
        step();
        got = {h12, pm, min, sec}; want = exp_q.pop_front(); tests++;
        if (got !== want) begin fails++; $display("FAIL tick_after got=%h want=%h", got, want); end
        tests++;
        if (upd_cnt - base_u !== 4) begin fails++; $display("FAIL tick_upd got=%0d want=4", upd_cnt - base_u); end
        run = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_count();
        set_load(17, 30, 12); run = 1'b1;
        exp_q.push_back(ref_disp(17, 30, 12));
        step(); load_valid = 1'b0;
        step();
        got = {h12, pm, min, sec}; want = exp_q.pop_front(); tests++;
        if (got !== want) begin fails++; $display("FAIL rst_pre got=%h want=%h", got, want); end
        step();
        rst_n = 1'b0;
        exp_q.push_back(ref_disp(0, 0, 0));
        #1;
        got = {h12, pm, min, sec}; want = exp_q.pop_front(); tests++;
        if (got !== want) begin fails++; $display("FAIL rst_async got=%h want=%h", got, want); end
        step();
        rst_n = 1'b1;
        exp_q.push_back(ref_disp(0, 0, 0));
        repeat (5) step();
        got = {h12, pm, min, sec}; want = exp_q.pop_front(); tests++;
        if (got !== want) begin fails++; $display("FAIL rst_idle_start got=%h want=%h", got, want); end
        exp_q.push_back(ref_disp(0, 0, 1));
        step();
        got = {h12, pm, min, sec}; want = exp_q.pop_front(); tests++;
        if (got !== want) begin fails++; $display("FAIL rst_first_tick got=%h want=%h", got, want); end
        run = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        int mn, sc;
        base_u = upd_cnt;
        for (int i = 0; i < 26; i++) begin
            if (i >= 2) begin
                got = {h12, pm, min, sec}; want = exp_q.pop_front(); tests++;
                if (got !== want) begin
                    fails++; $display("FAIL b2b_hour%0d got=%h want=%h", i - 2, got, want);
                end
            end
            if (i < 24) begin
                mn = int'($urandom_range(0, 59));
                sc = int'($urandom_range(0, 59));
                set_load(i, mn, sc);
                exp_q.push_back(ref_disp(i, mn, sc));
            end else begin
                load_valid = 1'b0;
            end
            step();
        end
        tests++;
        if (upd_cnt - base_u !== 24) begin fails++; $display("FAIL b2b_upd got=%0d want=24", upd_cnt - base_u); end
    endtask

    task automatic test_exclusive();
        tests++;
        if (both_cnt !== 0) begin fails++; $display("FAIL upd_err_overlap got=%0d want=0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_noon_rollover();
        test_midnight_wrap();
        test_illegal_load();
        test_load_on_tick();
        test_reset_mid_count();
        test_back_to_back();
        test_exclusive();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/h24_h12_clock.md
# h24_h12_clock

Free-running time-of-day keeper that counts seconds, minutes and hours internally in 24-hour format and presents the time in 12-hour format with an AM/PM flag. It is the 24h-to-12h companion of the team's existing 12h-to-24h hour converter. It sits between a loadable time source (24h format) and the 12h display path.

## Interface

Parameters:
- CLK_DIV, default 4: clk cycles per second; legal range 1..2^16.

Ports:
- clk  in  1  system clock. One clock domain only.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = time advances, 0 = time frozen and prescaler held.
- load_valid  in  1  load request, 24h format.
- load_ready  out  1  load accepted when both load_valid and load_ready are high.
- load_h24  in  5  hour to load, legal 0..23.
- load_min  in  6  minute to load, legal 0..59.
- load_sec  in  6  second to load, legal 0..59.
- h12  out  4  displayed hour, 1..12.
- pm  out  1  0 = AM, 1 = PM.
- min  out  6  displayed minute.
- sec  out  6  displayed second.
- upd  out  1  one-cycle pulse; outputs changed this cycle.
- load_err  out  1  one-cycle pulse; load rejected as out of range.

## Operation

- Internal registers:
  - hr24 (5b), mn (6b), sc (6b).
  - Prescaler pcnt, counting 0..CLK_DIV-1.
- State machine, 3 states:
  - IDLE: run=0.
  - COUNT: run=1.
  - LOADED: one cycle after any accepted load.
- State transitions:
  - IDLE→COUNT on run=1.
  - COUNT→IDLE on run=0.
  - Any state→LOADED on a load handshake.
  - LOADED→COUNT if run=1, otherwise LOADED→IDLE.
- Second tick: in COUNT, when pcnt==CLK_DIV-1, pcnt returns to 0 and the time increments by one second.
- Increment carries:
  - sc 59→0 carries into mn.
  - mn 59→0 carries into hr24.
  - hr24 23→0 at 23:59:59 → 00:00:00 wrap.
- load_ready is constant 1; a load is accepted in any state.
- Legal load:
  - hr24/mn/sc take the load values.
  - pcnt is cleared to 0.
  - Load takes priority over a same-cycle second tick; that tick is lost.
- Illegal load (h>23, m>59 or s>59):
  - Time and pcnt are unchanged.
  - load_err pulses one cycle later.
  - State does not go to LOADED.
- 24h→12h conversion:
  - hr24=0 → h12=12, pm=0.
  - hr24=1..11 → h12=hr24, pm=0.
  - hr24=12 → h12=12, pm=1.
  - hr24=13..23 → h12=hr24-12, pm=1.
  - Computed in 5 bits, truncated to 4; the result is always in the range 1..12.
- min/sec are direct copies of mn/sc.
- upd pulses on every time change: each tick and each legal load.

## Timing

- Reset values:
  - Internal: hr24=0, mn=0, sc=0, pcnt=0, state IDLE.
  - Outputs: h12=12, pm=0, min=0, sec=0, upd=0, load_err=0, load_ready=1.
- Latency:
  - Internal time registers update on the tick or load edge.
  - h12/pm/min/sec/upd/load_err are registered and appear 1 cycle later.
  - Total: 1 cycle from the event to visible outputs.
- After run rises: the first tick occurs CLK_DIV cycles later, counting pcnt from its held value.
- Reset asserted mid-count or mid-load: all state clears immediately (asynchronous). Deassertion is synchronised by the reset tree upstream.
- upd and load_err never assert in the same cycle.

## Structure

- Shared package (clock_pkg):
  - HR_MAX=23, MIN_MAX=59, SEC_MAX=59, HR_NOON=12.
  - State enum {IDLE, COUNT, LOADED}.
- One natural sub-module: h24_to_h12, a purely combinational conversion function, reused by the display path.
- The top level holds the prescaler, counters, FSM and output registers.

## Test plan

- Reset, then hold run=0 for 20 cycles → h12=12, pm=0, min=0, sec=0; upd never pulses.
- Load 11:59:58, run=1, CLK_DIV=4 → after 8 cycles h12=12, pm=1, min=0, sec=0; upd pulsed twice.
- Load 23:59:59, run=1 → next tick gives h12=12, pm=0, 00:00; the 24h wrap is verified.
- Load 24:00:00, then 13:60:00 → load_err pulses each time; outputs unchanged; no upd.
- Load 13:05:00 in the same cycle a tick is due → h12=1, pm=1, min=5, sec=0; the next tick comes CLK_DIV cycles later.
- Assert rst_n=0 for 1 cycle mid-count at 17:30:12 → outputs return to 12 AM 00:00 immediately, state IDLE.
